// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encoding, default frame geometry,
// and a width helper reused by both the receiver and the matching transmitter.
package serial_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } serial_state_e;

    localparam int unsigned DefDataBits   = 8;
    localparam int unsigned DefClksPerBit = 16;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages reset to RESET_VALUE so the output matches the line's idle level.
module bit_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            q      <= RESET_VALUE;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Framed asynchronous serial receiver: mid-bit sampling of an idle-high line, LSB-first
// deserialization, stop-bit check, and one-cycle valid / frame_err strobes.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DefDataBits,
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int unsigned H    = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = min_width(CLKS_PER_BIT);
    localparam int unsigned IdxW = min_width(DATA_BITS);

    localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic                 rxs;
    serial_state_e        state_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdxW-1:0]      idx_q;
    logic [DATA_BITS-1:0] sr_q;
    logic [DATA_BITS-1:0] sr_shift;
    logic                 brk_q;

    bit_sync #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    // New bit enters at the MSB so the first bit received ends in the LSB.
    always_comb begin
        sr_shift                = sr_q >> 1;
        sr_shift[DATA_BITS-1]   = rxs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
            brk_q     <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q != CntHalf) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else if (!rxs) begin
                        state_q <= StData;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StData: begin
                    if (cnt_q != CntLast) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else begin
                        sr_q  <= sr_shift;
                        cnt_q <= '0;
                        if (idx_q == IdxLast) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end
                end
                StStop: begin
                    if (cnt_q != CntLast) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= StIdle;
                            data    <= sr_q;
                            valid   <= 1'b1;
                            brk_q   <= 1'b0;
                        end else begin
                            // Line still low: rearm at once, but report only the first
                            // error of a break until a good frame clears it.
                            state_q   <= StStart;
                            frame_err <= !brk_q;
                            brk_q     <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
